// File: rtl/ahb_lite_resp_mux.sv
// ---------------------------------------------------------------------------
// ahb_lite_resp_mux
//
// Purpose:
//   AHB-Lite read-data / response multiplexer for up to four slaves, with a
//   built-in default slave that answers unmapped accesses.
//   - The address-phase slave select is captured on every edge where the bus
//     is ready (HREADY = 1) into a data-phase select register (sel_q).
//   - While a mapped slave is selected, its HRDATA/HREADYOUT/HRESP pass
//     straight through combinationally (no added latency).
//   - While nothing is selected, a small default-slave FSM drives the bus:
//     OKAY/zero-wait for IDLE/BUSY transfers, and the standard two-cycle
//     ERROR response for NONSEQ/SEQ transfers to unmapped addresses.
//   The outputs depend only on sel_q, the FSM state and the slave inputs;
//   HSEL and HTRANS only influence the registers.
//
// Ports:
//   HCLK                    in   bus clock, rising edge
//   HRESET                  in   synchronous, active-high reset
//   HSEL0..HSEL3            in   address-phase slave selects
//   HTRANS[1:0]             in   transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HRDATA0..HRDATA3        in   slave read data
//   HREADYOUT0..HREADYOUT3  in   slave ready outputs
//   HRESP0..HRESP3          in   slave responses (0 OKAY, 1 ERROR)
//   HRDATA                  out  read data to master
//   HREADY                  out  bus ready (to master and all slaves)
//   HRESP                   out  response to master
// ---------------------------------------------------------------------------
module ahb_lite_resp_mux #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL0,
  input  logic                  HSEL1,
  input  logic                  HSEL2,
  input  logic                  HSEL3,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HRDATA0,
  input  logic [DATA_WIDTH-1:0] HRDATA1,
  input  logic [DATA_WIDTH-1:0] HRDATA2,
  input  logic [DATA_WIDTH-1:0] HRDATA3,
  input  logic                  HREADYOUT0,
  input  logic                  HREADYOUT1,
  input  logic                  HREADYOUT2,
  input  logic                  HREADYOUT3,
  input  logic                  HRESP0,
  input  logic                  HRESP1,
  input  logic                  HRESP2,
  input  logic                  HRESP3,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADY,
  output logic                  HRESP
);

  // Data-phase select encoding.
  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_S0   = 3'd1,
    SEL_S1   = 3'd2,
    SEL_S2   = 3'd3,
    SEL_S3   = 3'd4
  } sel_e;

  // Default-slave states.
  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_e;

  sel_e sel_q, sel_d;
  ds_e  ds_q;
  logic ds_hready_q;
  logic ds_hresp_q;

  logic capture;
  logic trans_active;
  sel_e sel_capt;

  // Fixed-priority encode of the address-phase selects: lowest index wins,
  // so overlapping decodes never produce contention on the data bus.
  function automatic sel_e encode_sel(input logic [3:0] hsel);
    sel_e s;
    if (hsel[0])      s = SEL_S0;
    else if (hsel[1]) s = SEL_S1;
    else if (hsel[2]) s = SEL_S2;
    else if (hsel[3]) s = SEL_S3;
    else              s = SEL_NONE;
    return s;
  endfunction

  // Only NONSEQ and SEQ are real transfers; IDLE and BUSY must get OKAY.
  function automatic logic is_active(input logic [1:0] htrans);
    logic a;
    case (htrans)
      2'b10, 2'b11: a = 1'b1;
      default:      a = 1'b0;
    endcase
    return a;
  endfunction

  // Default-slave output decode, used to load the registered FSM outputs
  // together with the next state so they never glitch.
  function automatic logic ds_ready_of(input ds_e s);
    return (s != DS_ERR1);
  endfunction

  function automatic logic ds_resp_of(input ds_e s);
    return (s == DS_ERR1) || (s == DS_ERR2);
  endfunction

  // An address phase is accepted on every edge where the bus is ready.
  assign capture      = HREADY;
  assign trans_active = is_active(HTRANS);
  assign sel_capt     = encode_sel({HSEL3, HSEL2, HSEL1, HSEL0});

  // While a data phase is stalled the select must not move, regardless of
  // what the decoder shows for the next (pending) address phase.
  always_comb begin
    sel_d = sel_q;
    if (capture) begin
      sel_d = sel_capt;
    end
  end

  // --- Select register ---
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_q <= SEL_NONE;
    end else begin
      sel_q <= sel_d;
    end
  end

  // --- Default-slave FSM with registered outputs ---
  // DS_ERR1 always advances: the two-cycle ERROR cannot be stretched or cut
  // short by any slave input. DS_ERR2 has HREADY = 1, so its edge is also a
  // capture edge and may start a new error back-to-back.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ds_q        <= DS_IDLE;
      ds_hready_q <= 1'b1;
      ds_hresp_q  <= 1'b0;
    end else begin
      case (ds_q)
        DS_ERR1: begin
          ds_q        <= DS_ERR2;
          ds_hready_q <= ds_ready_of(DS_ERR2);
          ds_hresp_q  <= ds_resp_of(DS_ERR2);
        end
        default: begin
          if (capture) begin
            if ((sel_capt == SEL_NONE) && trans_active) begin
              ds_q        <= DS_ERR1;
              ds_hready_q <= ds_ready_of(DS_ERR1);
              ds_hresp_q  <= ds_resp_of(DS_ERR1);
            end else begin
              ds_q        <= DS_IDLE;
              ds_hready_q <= ds_ready_of(DS_IDLE);
              ds_hresp_q  <= ds_resp_of(DS_IDLE);
            end
          end
        end
      endcase
    end
  end

  // --- Data-phase output mux ---
  // Purely a function of sel_q, the default-slave registers and the slave
  // inputs; HSEL/HTRANS never reach the outputs combinationally.
  always_comb begin
    HRDATA = '0;
    HREADY = ds_hready_q;
    HRESP  = ds_hresp_q;
    case (sel_q)
      SEL_S0: begin
        HRDATA = HRDATA0;
        HREADY = HREADYOUT0;
        HRESP  = HRESP0;
      end
      SEL_S1: begin
        HRDATA = HRDATA1;
        HREADY = HREADYOUT1;
        HRESP  = HRESP1;
      end
      SEL_S2: begin
        HRDATA = HRDATA2;
        HREADY = HREADYOUT2;
        HRESP  = HRESP2;
      end
      SEL_S3: begin
        HRDATA = HRDATA3;
        HREADY = HREADYOUT3;
        HRESP  = HRESP3;
      end
      default: begin
        HRDATA = '0;
        HREADY = ds_hready_q;
        HRESP  = ds_hresp_q;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_lite_resp_mux.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_resp_mux
//
// Self-checking bench for ahb_lite_resp_mux. Each stimulus cycle drives the
// address-phase controls and the slave outputs, and pushes the bus outputs
// expected during that same cycle onto a scoreboard queue; a negedge monitor
// pops and compares.
// ---------------------------------------------------------------------------
module tb_ahb_lite_resp_mux;

  localparam int DW = 32;
  localparam logic [DW-1:0] D0 = 32'hDEAD_BEEF;
  localparam logic [DW-1:0] D1 = 32'hA5A5_0001;
  localparam logic [DW-1:0] D2 = 32'h2222_2222;
  localparam logic [DW-1:0] D3 = 32'h3333_3333;

  logic          HCLK;
  logic          HRESET;
  logic          HSEL0, HSEL1, HSEL2, HSEL3;
  logic [1:0]    HTRANS;
  logic [DW-1:0] HRDATA0, HRDATA1, HRDATA2, HRDATA3;
  logic          HREADYOUT0, HREADYOUT1, HREADYOUT2, HREADYOUT3;
  logic          HRESP0, HRESP1, HRESP2, HRESP3;
  logic [DW-1:0] HRDATA;
  logic          HREADY;
  logic          HRESP;

  ahb_lite_resp_mux #(.DATA_WIDTH(DW)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .HSEL0      (HSEL0),
    .HSEL1      (HSEL1),
    .HSEL2      (HSEL2),
    .HSEL3      (HSEL3),
    .HTRANS     (HTRANS),
    .HRDATA0    (HRDATA0),
    .HRDATA1    (HRDATA1),
    .HRDATA2    (HRDATA2),
    .HRDATA3    (HRDATA3),
    .HREADYOUT0 (HREADYOUT0),
    .HREADYOUT1 (HREADYOUT1),
    .HREADYOUT2 (HREADYOUT2),
    .HREADYOUT3 (HREADYOUT3),
    .HRESP0     (HRESP0),
    .HRESP1     (HRESP1),
    .HRESP2     (HRESP2),
    .HRESP3     (HRESP3),
    .HRDATA     (HRDATA),
    .HREADY     (HREADY),
    .HRESP      (HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [DW-1:0] data;
    logic          rdy;
    logic          resp;
    string         tag;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs,
                          input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  always @(negedge HCLK) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check_eq({e.tag, ".hready"}, {31'd0, HREADY}, {31'd0, e.rdy});
      check_eq({e.tag, ".hresp"},  {31'd0, HRESP},  {31'd0, e.resp});
      check_eq({e.tag, ".hrdata"}, HRDATA, e.data);
    end
  end

  // One bus cycle: drive controls, slave ready/resp, reset, and the outputs
  // expected for this cycle (which reflect the selection captured earlier).
  task automatic cyc(input logic [3:0] hsel, input logic [1:0] htrans,
                     input logic [3:0] rdy, input logic [3:0] rsp,
                     input logic rst, input logic exp_rdy,
                     input logic exp_resp, input logic [DW-1:0] exp_data,
                     input string tag);
    exp_t e;
    @(posedge HCLK);
    #1;
    {HSEL3, HSEL2, HSEL1, HSEL0} = hsel;
    HTRANS = htrans;
    {HREADYOUT3, HREADYOUT2, HREADYOUT1, HREADYOUT0} = rdy;
    {HRESP3, HRESP2, HRESP1, HRESP0} = rsp;
    HRESET = rst;
    e.data = exp_data;
    e.rdy  = exp_rdy;
    e.resp = exp_resp;
    e.tag  = tag;
    sbq.push_back(e);
  endtask

  initial begin
    HRESET = 1'b1;
    {HSEL3, HSEL2, HSEL1, HSEL0} = 4'b0000;
    HTRANS = 2'b00;
    HRDATA0 = D0; HRDATA1 = D1; HRDATA2 = D2; HRDATA3 = D3;
    {HREADYOUT3, HREADYOUT2, HREADYOUT1, HREADYOUT0} = 4'b1111;
    {HRESP3, HRESP2, HRESP1, HRESP0} = 4'b0000;
    repeat (2) @(posedge HCLK);

    //  hsel     htrans  rdy      rsp      rst  rdy  resp data
    cyc(4'b0010, 2'b10, 4'b1111, 4'b0000, 0,   1,   0,   '0, "reset");
    cyc(4'b0000, 2'b00, 4'b1111, 4'b0000, 0,   1,   0,   D1, "rd_s1");
    cyc(4'b0100, 2'b10, 4'b1111, 4'b0000, 0,   1,   0,   '0, "unmapped_idle");
    // Slave 2 stalls three cycles while the decoder points at slave 0.
    cyc(4'b0001, 2'b10, 4'b1011, 4'b0000, 0,   0,   0,   D2, "wait1");
    cyc(4'b0001, 2'b10, 4'b1011, 4'b0000, 0,   0,   0,   D2, "wait2");
    cyc(4'b0001, 2'b10, 4'b1011, 4'b0000, 0,   0,   0,   D2, "wait3");
    cyc(4'b0000, 2'b10, 4'b1111, 4'b0000, 0,   1,   0,   D2, "wait_done");
    // Unmapped NONSEQ error; slave ready inputs low must not affect it.
    cyc(4'b0000, 2'b00, 4'b0000, 4'b1111, 0,   0,   1,   '0, "err1");
    cyc(4'b0000, 2'b00, 4'b0000, 4'b1111, 0,   1,   1,   '0, "err2");
    cyc(4'b0000, 2'b11, 4'b1111, 4'b0000, 0,   1,   0,   '0, "err_done");
    // Back-to-back unmapped SEQ errors.
    cyc(4'b0000, 2'b11, 4'b1111, 4'b0000, 0,   0,   1,   '0, "b2b_err1a");
    cyc(4'b0000, 2'b11, 4'b1111, 4'b0000, 0,   1,   1,   '0, "b2b_err2a");
    cyc(4'b0000, 2'b00, 4'b1111, 4'b0000, 0,   0,   1,   '0, "b2b_err1b");
    cyc(4'b1001, 2'b10, 4'b1111, 4'b0000, 0,   1,   1,   '0, "b2b_err2b");
    // Overlapping selects resolve to slave 0, then switch straight to S3.
    cyc(4'b1000, 2'b10, 4'b1111, 4'b0000, 0,   1,   0,   D0, "overlap_s0");
    cyc(4'b0000, 2'b10, 4'b1111, 4'b1000, 0,   1,   1,   D3, "switch_s3");
    // Reset asserted during ERR1 aborts the error.
    cyc(4'b0000, 2'b00, 4'b1111, 4'b0000, 1,   0,   1,   '0, "err1_pre_rst");
    cyc(4'b0000, 2'b00, 4'b1111, 4'b0000, 0,   1,   0,   '0, "rst_mid_err");
    // Reset during a slave wait drops the selection; outputs unchanged
    // while HRESET is high before the edge.
    cyc(4'b0100, 2'b10, 4'b1011, 4'b0000, 0,   1,   0,   '0, "pre_wait");
    cyc(4'b0000, 2'b00, 4'b1011, 4'b0000, 1,   0,   0,   D2, "wait_pre_rst");
    cyc(4'b0000, 2'b00, 4'b1011, 4'b0000, 0,   1,   0,   '0, "rst_drop_sel");
    // Reset beats a capture on the same edge.
    cyc(4'b0010, 2'b10, 4'b1111, 4'b0000, 1,   1,   0,   '0, "cap_with_rst");
    cyc(4'b0000, 2'b00, 4'b1111, 4'b0000, 0,   1,   0,   '0, "rst_over_cap");

    // Let the monitor drain the last expectation, bounded to a few cycles.
    for (int i = 0; i < 4 && sbq.size() > 0; i++) @(posedge HCLK);
    check_eq("sb_drain", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ahb_lite_resp_mux.md
AHB_LITE_RESP_MUX -- requirements
Module: ahb_lite_resp_mux

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of HRDATA and of every HRDATAn.
REQ-002 The block SHALL have one clock and a reset that is synchronous and active-high. Ports are listed below.
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESET  in  1  reset; synchronous, active-high.
- HSEL0..HSEL3  in  1 each  address-phase slave selects from the address decoder.
- HTRANS  in  2  master transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HRDATA0..HRDATA3  in  DATA_WIDTH each  slave read data.
- HREADYOUT0..HREADYOUT3  in  1 each  slave ready outputs.
- HRESP0..HRESP3  in  1 each  slave responses: 0 OKAY, 1 ERROR.
- HRDATA  out  DATA_WIDTH  read data to the master.
- HREADY  out  1  bus ready; goes to the master and back to all slaves.
- HRESP  out  1  response to the master.

Function
REQ-003 The block SHALL hold a data-phase select register, sel_q, with encoding NONE, S0, S1, S2, S3.
REQ-004 On each rising edge where the HREADY output is 1, sel_q SHALL load the current HSEL inputs (the address-phase capture).
REQ-005 When HREADY is 0, sel_q SHALL hold its value, and HSEL and HTRANS SHALL be ignored.
REQ-006 If more than one HSELn is high at capture, the lowest index SHALL win. If no HSELn is high, sel_q SHALL load NONE.
REQ-007 When sel_q = Sn, the outputs SHALL be combinational pass-throughs in the same cycle, with zero added latency: HRDATA = HRDATAn, HREADY = HREADYOUTn, HRESP = HRESPn.
REQ-008 When sel_q = NONE, the outputs SHALL come from an internal default slave. HRDATA SHALL be 0 in every default-slave state.
REQ-009 The default-slave FSM SHALL have three states, with these outputs:
- DS_IDLE: HREADY = 1, HRESP = 0.
- DS_ERR1: HREADY = 0, HRESP = 1.
- DS_ERR2: HREADY = 1, HRESP = 1.
REQ-010 The FSM SHALL go to DS_ERR1 on any capture edge where no HSELn is high and HTRANS[1] = 1 (NONSEQ or SEQ).
REQ-011 The FSM SHALL move from DS_ERR1 to DS_ERR2 unconditionally on the next edge.
REQ-012 From DS_ERR2, the FSM SHALL apply REQ-010 again (that edge is a capture edge). Otherwise it SHALL go to DS_IDLE.
REQ-013 An unmapped capture with HTRANS = IDLE or BUSY SHALL give sel_q = NONE and DS_IDLE, which means an OKAY, zero-wait response.
REQ-014 A capture to a mapped slave SHALL force the FSM to DS_IDLE.
REQ-015 The ERROR response SHALL always be exactly two cycles: HRESP = 1 in both cycles, with HREADY 0 then 1. No slave input SHALL shorten or stretch it.
REQ-016 A mapped slave that holds HREADYOUTn = 0 SHALL keep sel_q fixed for the whole wait, with no limit on the number of cycles.
REQ-017 Back-to-back transfers to different slaves SHALL switch the mux on the edge that completes the previous data phase, with no idle cycle inserted.
REQ-018 HRDATA, HREADY and HRESP SHALL depend only on sel_q, the FSM state and the slave inputs. They SHALL have no combinational path from HSEL or HTRANS.

Reset
REQ-019 While HRESET = 1 at a rising edge, the block SHALL set sel_q = NONE and the FSM to DS_IDLE.
REQ-020 After that edge, the outputs SHALL be HREADY = 1, HRESP = 0 and HRDATA = 0.
REQ-021 Reset SHALL take priority over every other transition, including:
- a capture in the same cycle;
- a reset during DS_ERR1 or DS_ERR2, which SHALL abort the error sequence;
- a reset during a mapped slave's wait state, which SHALL drop the selection.
REQ-022 HRESET SHALL take effect only on the clock edge; asserting it between edges SHALL not change the outputs.

Verification
REQ-023 Single read to slave 1: HSEL1 = 1, HTRANS = 10, HRDATA1 = 0xA5A5_0001, HREADYOUT1 = 1 -> next cycle HRDATA = 0xA5A5_0001, HREADY = 1, HRESP = 0.
REQ-024 Wait state: slave 2 selected, HREADYOUT2 = 0 for 3 cycles then 1. During the wait, HSEL0 = 1 and HRDATA0 = 0xDEAD_BEEF -> HREADY stays 0 for 3 cycles and HRDATA follows HRDATA2 throughout.
REQ-025 Unmapped NONSEQ: all HSEL = 0, HTRANS = 10 -> next cycle HREADY = 0, HRESP = 1. The cycle after that, HREADY = 1 and HRESP = 1. Then the block returns to DS_IDLE with HREADY = 1 and HRESP = 0.
REQ-026 Two back-to-back unmapped SEQ transfers (the second captured in DS_ERR2) -> the HRESP = 1 pattern 0/1, 1/1 (HREADY/HRESP) repeats twice with no OKAY cycle between. Unmapped HTRANS = 00 -> HREADY = 1, HRESP = 0 with no error.
REQ-027 Reset mid-error: assert HRESET for one edge while in DS_ERR1 -> the next cycle gives HREADY = 1, HRESP = 0, HRDATA = 0.
REQ-028 Overlap: HSEL0 = 1 and HSEL3 = 1 at capture -> the slave 0 signals are muxed out.
